// File: rtl/memtest_mem_responder_if.sv
// Request/response bus between a memory tester (master) and the memory responder (slave).
// Requests are level-sampled by the responder; completions are single-cycle pulses.
interface memtest_mem_responder_if #(
  parameter int unsigned DATUM_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 8
);
  logic                   i_wr_req;
  logic                   i_rd_req;
  logic [ADDR_WIDTH-1:0]  i_address;
  logic [DATUM_WIDTH-1:0] i_memory_data_write;
  logic                   o_memory_write_ready;
  logic                   o_memory_read_valid;
  logic [DATUM_WIDTH-1:0] o_memory_data_read;
  logic                   o_busy;

  modport master (
    output i_wr_req, i_rd_req, i_address, i_memory_data_write,
    input  o_memory_write_ready, o_memory_read_valid, o_memory_data_read, o_busy
  );

  modport slave (
    input  i_wr_req, i_rd_req, i_address, i_memory_data_write,
    output o_memory_write_ready, o_memory_read_valid, o_memory_data_read, o_busy
  );
endinterface

// File: rtl/memtest_mem_responder.sv
// Word-addressed memory model with fixed write/read latency; MEM_FAULT_INJECT_EN forces a stuck read bit.
// Latency: ready/valid pulse one cycle after the WR_LATENCY/RD_LATENCY-th edge past the request.
// Backpressure: none queued; requests arriving while busy are dropped and must be re-asserted.
module memtest_mem_responder #(
  parameter int unsigned DATUM_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WR_LATENCY  = 2,
  parameter int unsigned RD_LATENCY  = 3,
  parameter int unsigned STUCK_BIT   = 0,
  parameter int unsigned STUCK_VALUE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_sync,
  memtest_mem_responder_if.slave bus
);

  if (WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_bad_wr_latency
    $error("WR_LATENCY must be in 1..15");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd_latency
    $error("RD_LATENCY must be in 1..15");
  end
  if (STUCK_BIT >= DATUM_WIDTH || STUCK_VALUE > 1) begin : g_bad_stuck
    $error("STUCK_BIT must index a datum bit and STUCK_VALUE must be 0 or 1");
  end

  localparam logic [3:0] WR_CNT0 = 4'(WR_LATENCY - 1);
  localparam logic [3:0] RD_CNT0 = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_nxt;
  logic [DATUM_WIDTH-1:0] wdata_q, wdata_nxt;
  logic                   wr_ready_q, wr_ready_nxt;
  logic                   rd_valid_q, rd_valid_nxt;
  logic [DATUM_WIDTH-1:0] rdata_q, rdata_fx;
  logic                   mem_we, rdata_ld;

  logic [DATUM_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    wr_ready_nxt = 1'b0;
    rd_valid_nxt = 1'b0;
    mem_we       = 1'b0;
    rdata_ld     = 1'b0;
    case (state)
      IDLE: begin
        // write has priority; a simultaneous read is dropped
        if (bus.i_wr_req) begin
          addr_nxt  = bus.i_address;
          wdata_nxt = bus.i_memory_data_write;
          cnt_nxt   = WR_CNT0;
          state_nxt = WR_WAIT;
        end else if (bus.i_rd_req) begin
          addr_nxt  = bus.i_address;
          cnt_nxt   = RD_CNT0;
          state_nxt = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          mem_we       = 1'b1;
          wr_ready_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          rdata_ld     = 1'b1;
          rd_valid_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata_fx = mem[addr_q];
`ifdef MEM_FAULT_INJECT_EN
    rdata_fx[STUCK_BIT] = STUCK_VALUE[0];
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wr_ready_q <= wr_ready_nxt;
      rd_valid_q <= rd_valid_nxt;
      if (rdata_ld) rdata_q <= rdata_fx;
    end
  end

  always_ff @(posedge i_clk) begin
    addr_q  <= addr_nxt;
    wdata_q <= wdata_nxt;
  end

  // reset on the commit edge must abort the write, so the enable is gated here too
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst_sync) mem[addr_q] <= wdata_q;
  end

  assign bus.o_memory_write_ready = wr_ready_q;
  assign bus.o_memory_read_valid  = rd_valid_q;
  assign bus.o_memory_data_read   = rdata_q;
  assign bus.o_busy               = (state != IDLE);

endmodule
